// File: rtl/filt_boxcar_mc_pkg.sv
// Shared filter package: clog2 helper and width derivations reused across filt_* blocks.
//   filt_clog2(v)      ceil(log2(v)), 0 for v <= 1
//   filt_cw(nch)       channel tag width, at least 1
//   filt_lw(max_pow)   len_pow port width
//   filt_sw(dw, mp)    full-precision accumulator width
package filt_boxcar_mc_pkg;

    function automatic int filt_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int filt_cw(input int num_channels);
        int w;
        w = filt_clog2(num_channels);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int filt_lw(input int max_power);
        return filt_clog2(max_power + 1);
    endfunction

    function automatic int filt_sw(input int data_width, input int max_power);
        return data_width + max_power;
    endfunction

endpackage

// File: rtl/filt_boxcar_mc_if.sv
// Sample/result bus of the multi-channel boxcar filter.
//   master: drives in_valid/in_chan/data_in, observes in_ready and the result strobe
//   slave : the filter side
interface filt_boxcar_mc_if
    import filt_boxcar_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4
);
    localparam int CW = filt_cw(NUM_CHANNELS);

    logic                         in_valid;
    logic                         in_ready;
    logic [CW-1:0]                in_chan;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         out_valid;
    logic [CW-1:0]                out_chan;
    logic signed [DATA_WIDTH-1:0] avg_out;
    logic                         out_primed;

    modport master (
        output in_valid, in_chan, data_in,
        input  in_ready, out_valid, out_chan, avg_out, out_primed
    );

    modport slave (
        input  in_valid, in_chan, data_in,
        output in_ready, out_valid, out_chan, avg_out, out_primed
    );

endinterface

// File: rtl/filt_dline_ram.sv
// Delay-line storage for all channels: simple dual-port distributed RAM, one write port and
// one read port with a registered (1-cycle) read. Reading the address being written returns
// the old contents, which the filter relies on when the window spans the whole line.
//   clk       clock
//   i_we      write enable
//   i_waddr   write address {chan, ptr}
//   i_wdata   write data
//   i_raddr   read address {chan, ptr}
//   o_rdata   read data, valid the cycle after i_raddr
module filt_dline_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/filt_boxcar_mc.sv
// Multi-channel moving-average (boxcar) filter with a power-of-two window.
//   clk, rst     clock, synchronous active-high reset
//   i_len_pow    window = 2**i_len_pow, clamped to MAX_POWER; a change flushes all channels
//   io_bus       sample in (valid/ready/chan/data) and result out (valid/chan/avg/primed)
// Pipeline: accept edge writes the delay line, bumps pointer/fill and issues the oldest-sample
// read; next edge updates the channel sum; the edge after registers the averaged result.
module filt_boxcar_mc
    import filt_boxcar_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_POWER    = 5,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [filt_lw(MAX_POWER)-1:0] i_len_pow,
    filt_boxcar_mc_if.slave               io_bus
);

    localparam int CW = filt_cw(NUM_CHANNELS);
    localparam int LW = filt_lw(MAX_POWER);
    localparam int SW = filt_sw(DATA_WIDTH, MAX_POWER);
    localparam int PW = MAX_POWER;
    localparam int FW = MAX_POWER + 1;
    localparam int AW = CW + PW;
    localparam logic [FW-1:0] FILL_MAX = FW'(1) << MAX_POWER;

    // Per-channel state
    logic signed [SW-1:0] r_sum  [NUM_CHANNELS];
    logic [PW-1:0]        r_ptr  [NUM_CHANNELS];
    logic [FW-1:0]        r_fill [NUM_CHANNELS];

    logic [LW-1:0] r_len;
    logic          r_hold;

    logic                         r_s1_valid, r_s1_use_old, r_s1_primed;
    logic [CW-1:0]                r_s1_chan;
    logic signed [DATA_WIDTH-1:0] r_s1_data;
    logic [LW-1:0]                r_s1_len;

    logic                 r_s2_valid, r_s2_primed;
    logic [CW-1:0]        r_s2_chan;
    logic signed [SW-1:0] r_s2_sum;
    logic [LW-1:0]        r_s2_len;

    logic                         r_out_valid, r_out_primed;
    logic [CW-1:0]                r_out_chan;
    logic signed [DATA_WIDTH-1:0] r_out_avg;

    logic [LW-1:0]                w_len_new;
    logic                         w_len_chg, w_ready, w_acc;
    logic [FW-1:0]                w_win, w_fill_cur, w_fill_nxt;
    logic [PW-1:0]                w_ptr_cur, w_rd_ptr;
    logic signed [DATA_WIDTH-1:0] w_oldest;
    logic signed [SW-1:0]         w_s1_old, w_s1_sum;
    logic                         w_s2_neg;
    logic [SW-1:0]                w_s2_mag, w_s2_shr, w_s2_q;

    always_comb begin
        w_len_new = (i_len_pow > LW'(MAX_POWER)) ? LW'(MAX_POWER) : i_len_pow;
        w_len_chg = (w_len_new != r_len);
        w_ready   = ~rst & ~r_hold & ~w_len_chg;
        w_acc     = io_bus.in_valid & w_ready & (int'(io_bus.in_chan) < NUM_CHANNELS);
        w_win      = FW'(1) << r_len;
        w_fill_cur = r_fill[io_bus.in_chan];
        w_ptr_cur  = r_ptr[io_bus.in_chan];
        w_fill_nxt = (w_fill_cur == FILL_MAX) ? FILL_MAX : w_fill_cur + FW'(1);
        // Extra bit keeps a full-line window (2**MAX_POWER) from vanishing in PW bits.
        w_rd_ptr   = PW'({1'b0, w_ptr_cur} - w_win);
    end

    filt_dline_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW),
        .DEPTH      (NUM_CHANNELS << MAX_POWER)
    ) u_dline (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr ({io_bus.in_chan, w_ptr_cur}),
        .i_wdata (io_bus.data_in),
        .i_raddr ({io_bus.in_chan, w_rd_ptr}),
        .o_rdata (w_oldest)
    );

    // Sum read-modify-write completes in one cycle, so a back-to-back sample on the same
    // channel always sees the updated sum.
    always_comb begin
        w_s1_old = r_s1_use_old ? SW'(w_oldest) : '0;
        w_s1_sum = r_sum[r_s1_chan] + SW'(r_s1_data) - w_s1_old;
        // Truncate toward zero: shift the magnitude. -(-2**(SW-1)) wraps to the same bit
        // pattern, which is still the right unsigned magnitude.
        w_s2_neg = r_s2_sum[SW-1];
        w_s2_mag = w_s2_neg ? -r_s2_sum : r_s2_sum;
        w_s2_shr = w_s2_mag >> r_s2_len;
        w_s2_q   = w_s2_neg ? -w_s2_shr : w_s2_shr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_hold <= 1'b1;
        end else begin
            r_hold <= 1'b0;
            if (w_len_chg) begin
                r_len <= w_len_new;
            end
        end
    end

    // A flush clears sums after the in-flight sample's write, so it wins over that write;
    // the in-flight result itself still leaves the pipeline with the old window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_sum[c]  <= '0;
                r_ptr[c]  <= '0;
                r_fill[c] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_ptr[io_bus.in_chan]  <= w_ptr_cur + PW'(1);
                r_fill[io_bus.in_chan] <= w_fill_nxt;
            end
            if (r_s1_valid) begin
                r_sum[r_s1_chan] <= w_s1_sum;
            end
            if (w_len_chg) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_sum[c]  <= '0;
                    r_fill[c] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_use_old <= 1'b0;
            r_s1_primed  <= 1'b0;
            r_s1_chan    <= '0;
            r_s1_data    <= '0;
            r_s1_len     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_primed  <= 1'b0;
            r_s2_chan    <= '0;
            r_s2_sum     <= '0;
            r_s2_len     <= '0;
            r_out_valid  <= 1'b0;
            r_out_primed <= 1'b0;
            r_out_chan   <= '0;
            r_out_avg    <= '0;
        end else begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_chan    <= io_bus.in_chan;
                r_s1_data    <= io_bus.data_in;
                r_s1_use_old <= (w_fill_cur >= w_win);
                r_s1_primed  <= (w_fill_nxt >= w_win);
                r_s1_len     <= r_len;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_chan   <= r_s1_chan;
                r_s2_sum    <= w_s1_sum;
                r_s2_primed <= r_s1_primed;
                r_s2_len    <= r_s1_len;
            end
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_chan   <= r_s2_chan;
                r_out_avg    <= DATA_WIDTH'(w_s2_q);
                r_out_primed <= r_s2_primed;
            end
        end
    end

    assign io_bus.in_ready   = w_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_chan   = r_out_chan;
    assign io_bus.avg_out    = r_out_avg;
    assign io_bus.out_primed = r_out_primed;

endmodule

// File: tb/tb_filt_boxcar_mc.sv
// Bench for filt_boxcar_mc: directed scenarios plus random traffic, every result checked
// against a per-channel sample-history model (sum of the last 2**len samples / 2**len).
module tb_filt_boxcar_mc;

    localparam int DW   = 16;
    localparam int MAXP = 5;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int LW   = 3;

    typedef struct {
        int     due;
        int     ch;
        longint avg;
        bit     primed;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [LW-1:0] len_drv;

    filt_boxcar_mc_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();

    filt_boxcar_mc #(
        .DATA_WIDTH   (DW),
        .MAX_POWER    (MAXP),
        .NUM_CHANNELS (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_len_pow (len_drv),
        .io_bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    bit     m_started = 0;
    bit     m_hold    = 1;
    int     m_len     = 0;
    int     m_zero    = 0;
    longint hist [NCH][$];
    exp_t   exp_q [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint rnd_sample();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return r;
    endfunction

    task automatic clear_hist();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic tick(input bit v, input int ch, input longint d);
        exp_t   e;
        bit     ready;
        bit     acc;
        int     lenc;
        int     w;
        int     n;
        longint s;
        bus.in_valid = v;
        bus.in_chan  = CW'(ch);
        bus.data_in  = DW'(d);
        @(negedge clk);
        lenc  = (int'(len_drv) > MAXP) ? MAXP : int'(len_drv);
        ready = !rst && !m_hold && (lenc == m_len);
        if (m_started) begin
            chk("in_ready", bus.in_ready, ready);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("out_valid", bus.out_valid, 1);
                chk("out_chan", bus.out_chan, e.ch);
                chk("avg_out", bus.avg_out, e.avg);
                chk("out_primed", bus.out_primed, e.primed);
            end else begin
                chk("out_valid_idle", bus.out_valid, 0);
            end
            if (m_zero > 0) begin
                chk("rst_avg_out", bus.avg_out, 0);
                chk("rst_out_chan", bus.out_chan, 0);
                chk("rst_out_primed", bus.out_primed, 0);
            end
        end
        acc = v && ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_started = 1;
            m_len     = 0;
            m_hold    = 1;
            m_zero    = 2;
            clear_hist();
            exp_q.delete();
        end else begin
            m_hold = 0;
            if (m_zero > 0) m_zero--;
            if (lenc != m_len) begin
                m_len = lenc;
                clear_hist();
            end else if (acc) begin
                hist[ch].push_back(d);
                if (hist[ch].size() > (1 << MAXP)) void'(hist[ch].pop_front());
                w = 1 << m_len;
                n = hist[ch].size();
                s = 0;
                for (int k = 0; k < w && k < n; k++) begin
                    s += hist[ch][n - 1 - k];
                end
                e.due    = cyc + 2;
                e.ch     = ch;
                e.avg    = s / longint'(w);
                e.primed = (n >= w);
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    initial begin
        int lens [4];
        lens = '{3, 0, 5, 7};
        rst          = 1'b1;
        len_drv      = '0;
        bus.in_valid = 1'b0;
        bus.in_chan  = '0;
        bus.data_in  = '0;

        idle(3);
        rst     = 1'b0;
        len_drv = 3;
        idle(1);

        // Window 8, constant 100 on ch0
        for (int i = 0; i < 8; i++) tick(1, 0, 100);
        idle(3);

        // Window 4, negative values truncate toward zero
        len_drv = 2;
        idle(1);
        for (int i = 0; i < 4; i++) tick(1, 1, -5);
        idle(3);

        // Back-to-back paired channels at several windows, incl. a clamped len_pow
        foreach (lens[li]) begin
            len_drv = LW'(lens[li]);
            idle(1);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < NCH; c++) begin
                    tick(1, c, rnd_sample());
                    tick(1, c, rnd_sample());
                end
            end
            idle(3);
        end

        // Random channel mix with gaps
        len_drv = 4;
        idle(1);
        for (int i = 0; i < 60; i++) begin
            tick(1'($urandom_range(0, 1)), int'($urandom_range(0, NCH - 1)), rnd_sample());
        end
        idle(3);

        // Full-scale, full window: no wrap at either extreme
        len_drv = 5;
        idle(1);
        for (int i = 0; i < 32; i++) tick(1, 2, 32767);
        for (int i = 0; i < 32; i++) tick(1, 2, -32768);
        idle(3);

        // Window change mid-stream: one refused cycle, then a fresh window of 2
        len_drv = 3;
        idle(1);
        tick(1, 0, 20);
        tick(1, 0, 30);
        len_drv = 1;
        tick(1, 0, 10);
        tick(1, 0, 10);
        idle(3);

        // Reset with two samples in flight
        len_drv = 3;
        idle(1);
        tick(1, 0, 50);
        tick(1, 1, 60);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        tick(1, 0, 8);
        idle(4);

        if (exp_q.size() != 0) begin
            chk("pending_results", exp_q.size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
